// File: rtl/ldpc_pkg.sv
// Shared definitions for the QC-LDPC encoder datapath: supported circulant
// sizes, default block counts, packer FSM states and frame sizing helpers.
package ldpc_pkg;

  localparam int unsigned Z_SMALL  = 27;
  localparam int unsigned Z_MEDIUM = 54;
  localparam int unsigned Z_LARGE  = 81;

  localparam int unsigned DEF_NUM_INFO_BLKS   = 20;
  localparam int unsigned DEF_NUM_PARITY_BLKS = 4;

  // Packer states: FILL accepts beats, HOLD presents a finished frame.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_e;

  // Number of bits carried by nblk circulant blocks of size z.
  function automatic int unsigned frame_bits(input int unsigned z,
                                             input int unsigned nblk);
    return z * nblk;
  endfunction

  // True for the circulant sizes the encoder supports.
  function automatic bit z_supported(input int unsigned z);
    return (z == Z_SMALL) || (z == Z_MEDIUM) || (z == Z_LARGE);
  endfunction

endpackage

// File: rtl/ldpc_info_packer.sv
// Packs a narrow valid/ready payload stream into NUM_INFO_BLKS circulant
// blocks of Z bits and holds the finished frame until the encoder takes it.
module ldpc_info_packer
  import ldpc_pkg::*;
#(
  parameter  int unsigned Z             = 54,
  parameter  int unsigned NUM_INFO_BLKS = DEF_NUM_INFO_BLKS,
  parameter  int unsigned IN_W          = 8,
  localparam int unsigned INFO_BITS     = frame_bits(Z, NUM_INFO_BLKS),
  localparam int unsigned NUM_BEATS     = (INFO_BITS + IN_W - 1) / IN_W,
  localparam int unsigned CNT_W         = $clog2(NUM_BEATS + 1)
) (
  input  logic                              CLK,
  input  logic                              rst_n,
  input  logic [IN_W-1:0]                   in_data,
  input  logic                              in_valid,
  input  logic                              in_last,
  output logic                              in_ready,
  output logic [NUM_INFO_BLKS-1:0][Z-1:0]   info_blk,
  output logic                              info_valid,
  input  logic                              info_ready,
  output logic                              frame_err,
  output logic [CNT_W-1:0]                  beat_cnt
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  packer_state_e        state;
  logic [INFO_BITS-1:0] frame_q;
  logic                 accept;
  logic                 last_slot;
  logic                 complete;

  // in_ready is only ever high in FILL, so it alone qualifies a beat.
  assign accept    = in_valid && in_ready;
  assign last_slot = (beat_cnt == LAST_BEAT);
  assign complete  = accept && (last_slot || in_last);
  assign info_blk  = frame_q;

  // Frame control: beat counting, FILL/HOLD sequencing and handshake outputs.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      beat_cnt   <= '0;
      in_ready   <= 1'b0;
      info_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (complete) begin
            state      <= HOLD;
            beat_cnt   <= '0;
            in_ready   <= 1'b0;
            info_valid <= 1'b1;
            // Clean only when in_last lands exactly on the final slot.
            frame_err  <= !(last_slot && in_last);
          end else begin
            in_ready <= 1'b1;
            if (accept) begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (info_ready) begin
            // in_ready stays low one more cycle: the bubble before refilling.
            state      <= FILL;
            info_valid <= 1'b0;
            frame_err  <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Frame storage: write the accepted beat into its slot, clear on FILL entry.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
    end else if (state == HOLD) begin
      if (info_ready) begin
        frame_q <= '0;
      end
    end else if (accept) begin
      // Slot select by counter compare; the final slot is clipped at INFO_BITS
      // so the unused high bits of a partial last beat are dropped.
      for (int unsigned n = 0; n < NUM_BEATS; n++) begin
        if (beat_cnt == CNT_W'(n)) begin
          for (int unsigned k = n * IN_W; (k < INFO_BITS) && (k < (n + 1) * IN_W); k++) begin
            frame_q[k] <= in_data[k - n * IN_W];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ldpc_info_packer.sv
// Self-checking bench for ldpc_info_packer: a Z=54 and a Z=27 instance driven
// with random and directed frames, checked against a bit-stream model.
module tb_ldpc_info_packer;

  localparam int unsigned BITS_A  = 1080;
  localparam int unsigned BEATS_A = 135;
  localparam int unsigned BITS_B  = 540;
  localparam int unsigned BEATS_B = 68;

  logic CLK = 1'b0;
  logic rst_n;

  logic [7:0]        a_in_data;
  logic              a_in_valid, a_in_last, a_in_ready;
  logic [19:0][53:0] a_info_blk;
  logic              a_info_valid, a_info_ready, a_frame_err;
  logic [7:0]        a_beat_cnt;

  logic [7:0]        b_in_data;
  logic              b_in_valid, b_in_last, b_in_ready;
  logic [19:0][26:0] b_info_blk;
  logic              b_info_valid, b_info_ready, b_frame_err;
  logic [6:0]        b_beat_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]    beats[$];
  logic [1079:0] got_f, exp_f, snap_f;

  ldpc_info_packer #(.Z(54), .NUM_INFO_BLKS(20), .IN_W(8)) u_dut_z54 (
    .CLK(CLK), .rst_n(rst_n),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_last(a_in_last), .in_ready(a_in_ready),
    .info_blk(a_info_blk), .info_valid(a_info_valid), .info_ready(a_info_ready),
    .frame_err(a_frame_err), .beat_cnt(a_beat_cnt)
  );

  ldpc_info_packer #(.Z(27), .NUM_INFO_BLKS(20), .IN_W(8)) u_dut_z27 (
    .CLK(CLK), .rst_n(rst_n),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last), .in_ready(b_in_ready),
    .info_blk(b_info_blk), .info_valid(b_info_valid), .info_ready(b_info_ready),
    .frame_err(b_frame_err), .beat_cnt(b_beat_cnt)
  );

  always #5 CLK = ~CLK;

  // Reference: flatten the beat queue into a serial bit stream, keep the
  // first info_bits of it, everything not delivered reads as zero.
  function automatic logic [1079:0] model_frame(input int info_bits);
    bit stream[$];
    logic [1079:0] f;
    f = '0;
    foreach (beats[n]) begin
      for (int j = 0; j < 8; j++) stream.push_back(beats[n][j]);
    end
    for (int k = 0; k < stream.size(); k++) begin
      if (k < info_bits) f[k] = stream[k];
    end
    return f;
  endfunction

  function automatic logic [1079:0] get_frame(input int dut);
    logic [1079:0] f;
    f = '0;
    if (dut == 0) f = a_info_blk;
    else f[539:0] = b_info_blk;
    return f;
  endfunction

  function automatic int first_diff(input logic [1079:0] x, input logic [1079:0] y);
    for (int k = 0; k < 1080; k++) if (x[k] !== y[k]) return k;
    return -1;
  endfunction

  task automatic push_beat(input int dut, input logic [7:0] d, input logic l);
    int  guard;
    logic rdy;
    guard = 0;
    if (dut == 0) begin a_in_data = d; a_in_valid = 1'b1; a_in_last = l; end
    else          begin b_in_data = d; b_in_valid = 1'b1; b_in_last = l; end
    rdy = (dut == 0) ? a_in_ready : b_in_ready;
    while (!rdy && guard < 200) begin
      @(negedge CLK);
      guard++;
      rdy = (dut == 0) ? a_in_ready : b_in_ready;
    end
    if (!rdy) begin
      tests_run++; tests_failed++;
      $display("FAIL push_timeout dut%0d: in_ready=0 after %0d cycles, required 1", dut, guard);
    end
    @(negedge CLK);
    if (dut == 0) begin a_in_valid = 1'b0; a_in_last = 1'b0; end
    else          begin b_in_valid = 1'b0; b_in_last = 1'b0; end
  endtask

  task automatic send_frame(input int dut, input int last_idx, input bit gaps);
    foreach (beats[i]) begin
      if (gaps && ($urandom_range(0, 1) == 1)) repeat ($urandom_range(1, 2)) @(negedge CLK);
      push_beat(dut, beats[i], (i == last_idx));
    end
  endtask

  task automatic consume(input int dut);
    if (dut == 0) a_info_ready = 1'b1; else b_info_ready = 1'b1;
    @(negedge CLK);
    if (dut == 0) a_info_ready = 1'b0; else b_info_ready = 1'b0;
  endtask

  task automatic fill_random(input int n);
    beats.delete();
    for (int i = 0; i < n; i++) beats.push_back(8'($urandom));
  endtask

  task automatic test_reset;
    #3;
    tests_run++; if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 0", a_in_ready); end
    tests_run++; if (a_info_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_info_valid: got %b want 0", a_info_valid); end
    tests_run++; if (a_frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b want 0", a_frame_err); end
    tests_run++; if (a_beat_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_beat_cnt: got %0d want 0", a_beat_cnt); end
    got_f = get_frame(0);
    tests_run++; if (got_f !== '0) begin tests_failed++; $display("FAIL reset_info_blk: first nonzero bit %0d, want all 0", first_diff(got_f, '0)); end
    repeat (2) @(negedge CLK);
    tests_run++; if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_hold_in_ready: got %b want 0", a_in_ready); end
    rst_n = 1'b1;
    @(negedge CLK);
    tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_a: in_ready got %b want 1", a_in_ready); end
    tests_run++; if (b_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_b: in_ready got %b want 1", b_in_ready); end
  endtask

  task automatic test_incrementing;
    beats.delete();
    for (int i = 0; i < int'(BEATS_A); i++) beats.push_back(8'(i));
    a_info_ready = 1'b1;
    send_frame(0, int'(BEATS_A) - 1, 1'b0);
    got_f = get_frame(0);
    exp_f = model_frame(int'(BITS_A));
    tests_run++; if (a_info_valid !== 1'b1) begin tests_failed++; $display("FAIL inc_latency: info_valid got %b want 1", a_info_valid); end
    tests_run++; if (got_f !== exp_f) begin tests_failed++; $display("FAIL inc_frame: first bad bit %0d", first_diff(got_f, exp_f)); end
    tests_run++; if (got_f[7:0] !== 8'h00) begin tests_failed++; $display("FAIL inc_byte0: got %h want 00", got_f[7:0]); end
    tests_run++; if (got_f[15:8] !== 8'h01) begin tests_failed++; $display("FAIL inc_byte1: got %h want 01", got_f[15:8]); end
    tests_run++; if (got_f[1079:1072] !== 8'h86) begin tests_failed++; $display("FAIL inc_last_byte: got %h want 86", got_f[1079:1072]); end
    tests_run++; if (a_frame_err !== 1'b0) begin tests_failed++; $display("FAIL inc_frame_err: got %b want 0", a_frame_err); end
    tests_run++; if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL inc_ready_lo1: got %b want 0", a_in_ready); end
    @(negedge CLK);
    tests_run++; if (a_info_valid !== 1'b0) begin tests_failed++; $display("FAIL inc_pulse: info_valid got %b want 0", a_info_valid); end
    tests_run++; if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL inc_ready_lo2: got %b want 0", a_in_ready); end
    @(negedge CLK);
    tests_run++; if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL inc_ready_back: got %b want 1", a_in_ready); end
    a_info_ready = 1'b0;
  endtask

  task automatic test_all_ones_z27;
    beats.delete();
    for (int i = 0; i < int'(BEATS_B); i++) beats.push_back(8'hFF);
    send_frame(1, int'(BEATS_B) - 1, 1'b0);
    got_f = get_frame(1);
    exp_f = '0;
    exp_f[539:0] = '1;
    tests_run++; if (b_info_valid !== 1'b1) begin tests_failed++; $display("FAIL z27_valid: got %b want 1", b_info_valid); end
    tests_run++; if (got_f !== exp_f) begin tests_failed++; $display("FAIL z27_ones: first bad bit %0d", first_diff(got_f, exp_f)); end
    tests_run++; if (b_frame_err !== 1'b0) begin tests_failed++; $display("FAIL z27_frame_err: got %b want 0", b_frame_err); end
    tests_run++; if (b_beat_cnt !== 7'd0) begin tests_failed++; $display("FAIL z27_beat_cnt: got %0d want 0", b_beat_cnt); end
    consume(1);
    // Full count without in_last: frame stored, flagged as an error.
    fill_random(int'(BEATS_B));
    send_frame(1, -1, 1'b1);
    got_f = get_frame(1);
    exp_f = model_frame(int'(BITS_B));
    tests_run++; if (b_info_valid !== 1'b1) begin tests_failed++; $display("FAIL z27_nolast_valid: got %b want 1", b_info_valid); end
    tests_run++; if (got_f !== exp_f) begin tests_failed++; $display("FAIL z27_nolast_frame: first bad bit %0d", first_diff(got_f, exp_f)); end
    tests_run++; if (b_frame_err !== 1'b1) begin tests_failed++; $display("FAIL z27_nolast_err: got %b want 1", b_frame_err); end
    consume(1);
  endtask

  task automatic test_early_last;
    fill_random(10);
    beats.push_back(8'hFF);
    send_frame(0, 10, 1'b0);
    got_f = get_frame(0);
    exp_f = model_frame(int'(BITS_A));
    tests_run++; if (a_info_valid !== 1'b1) begin tests_failed++; $display("FAIL early_valid: got %b want 1", a_info_valid); end
    tests_run++; if (got_f !== exp_f) begin tests_failed++; $display("FAIL early_frame: first bad bit %0d", first_diff(got_f, exp_f)); end
    tests_run++; if (got_f[87:80] !== 8'hFF) begin tests_failed++; $display("FAIL early_beat10: got %h want ff", got_f[87:80]); end
    tests_run++; if (a_frame_err !== 1'b1) begin tests_failed++; $display("FAIL early_err: got %b want 1", a_frame_err); end
    tests_run++; if (a_beat_cnt !== 8'd0) begin tests_failed++; $display("FAIL early_beat_cnt: got %0d want 0", a_beat_cnt); end
    consume(0);
  endtask

  task automatic test_hold_stall;
    fill_random(int'(BEATS_A));
    send_frame(0, int'(BEATS_A) - 1, 1'b1);
    snap_f = get_frame(0);
    exp_f = model_frame(int'(BITS_A));
    tests_run++; if (snap_f !== exp_f) begin tests_failed++; $display("FAIL stall_frame: first bad bit %0d", first_diff(snap_f, exp_f)); end
    for (int c = 0; c < 20; c++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'($urandom);
      @(negedge CLK);
      got_f = get_frame(0);
      tests_run++; if (got_f !== snap_f) begin tests_failed++; $display("FAIL stall_blk c%0d: first changed bit %0d", c, first_diff(got_f, snap_f)); end
      tests_run++; if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_ready c%0d: got %b want 0", c, a_in_ready); end
      tests_run++; if (a_info_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_valid c%0d: got %b want 1", c, a_info_valid); end
    end
    fill_random(int'(BEATS_A));
    a_in_data    = beats[0];
    a_info_ready = 1'b1;
    @(negedge CLK);
    a_info_ready = 1'b0;
    tests_run++; if (a_info_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_release: info_valid got %b want 0", a_info_valid); end
    tests_run++; if (a_beat_cnt !== 8'd0) begin tests_failed++; $display("FAIL stall_beat_cnt: got %0d want 0", a_beat_cnt); end
    send_frame(0, int'(BEATS_A) - 1, 1'b0);
    got_f = get_frame(0);
    exp_f = model_frame(int'(BITS_A));
    tests_run++; if (got_f !== exp_f) begin tests_failed++; $display("FAIL stall_next_frame: first bad bit %0d", first_diff(got_f, exp_f)); end
    tests_run++; if (a_frame_err !== 1'b0) begin tests_failed++; $display("FAIL stall_next_err: got %b want 0", a_frame_err); end
    consume(0);
  endtask

  task automatic test_async_reset;
    fill_random(int'(BEATS_A));
    for (int i = 0; i < 50; i++) push_beat(0, beats[i], 1'b0);
    tests_run++; if (a_beat_cnt !== 8'd50) begin tests_failed++; $display("FAIL arst_pre_cnt: got %0d want 50", a_beat_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    got_f = get_frame(0);
    tests_run++; if (a_beat_cnt !== 8'd0) begin tests_failed++; $display("FAIL arst_cnt: got %0d want 0", a_beat_cnt); end
    tests_run++; if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL arst_ready: got %b want 0", a_in_ready); end
    tests_run++; if (a_info_valid !== 1'b0) begin tests_failed++; $display("FAIL arst_valid: got %b want 0", a_info_valid); end
    tests_run++; if (got_f !== '0) begin tests_failed++; $display("FAIL arst_blk: first nonzero bit %0d", first_diff(got_f, '0)); end
    @(negedge CLK);
    rst_n = 1'b1;
    send_frame(0, int'(BEATS_A) - 1, 1'b1);
    got_f = get_frame(0);
    exp_f = model_frame(int'(BITS_A));
    tests_run++; if (a_info_valid !== 1'b1) begin tests_failed++; $display("FAIL arst_after_valid: got %b want 1", a_info_valid); end
    tests_run++; if (got_f !== exp_f) begin tests_failed++; $display("FAIL arst_after_frame: first bad bit %0d", first_diff(got_f, exp_f)); end
    tests_run++; if (a_frame_err !== 1'b0) begin tests_failed++; $display("FAIL arst_after_err: got %b want 0", a_frame_err); end
    consume(0);
  endtask

  task automatic test_back_to_back;
    for (int f = 0; f < 3; f++) begin
      fill_random(int'(BEATS_A));
      send_frame(0, int'(BEATS_A) - 1, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      got_f = get_frame(0);
      exp_f = model_frame(int'(BITS_A));
      tests_run++; if (a_info_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid f%0d: got %b want 1", f, a_info_valid); end
      tests_run++; if (got_f !== exp_f) begin tests_failed++; $display("FAIL b2b_frame f%0d: first bad bit %0d", f, first_diff(got_f, exp_f)); end
      tests_run++; if (a_frame_err !== 1'b0) begin tests_failed++; $display("FAIL b2b_err f%0d: got %b want 0", f, a_frame_err); end
      consume(0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_data = '0; a_in_valid = 1'b0; a_in_last = 1'b0; a_info_ready = 1'b0;
    b_in_data = '0; b_in_valid = 1'b0; b_in_last = 1'b0; b_info_ready = 1'b0;
    test_reset;
    test_incrementing;
    test_all_ones_z27;
    test_early_last;
    test_hold_stall;
    test_async_reset;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
